// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length/data/checksum word stream, writes the
// data words into instruction memory and releases the CPU once the image checks out.
module prog_loader #(
  parameter int unsigned MEM_WORDS = 100,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [31:0] im_addr,
  output logic [3:0]  im_write,
  output logic [31:0] im_data,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam int IDXW = $clog2(MEM_WORDS + 1);

  typedef enum logic [2:0] {LEN, DATA, CSUM, RUN, ERR} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   n_q, n_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [31:0]       xor_q, xor_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              cpu_rst_q, done_q, err_q;
  logic              load_st;
  logic              accept;

  // Ready follows the state; it is also held low while rst is asserted so the
  // port shows its reset value of 0 during reset.
  assign load_st = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign s_ready = load_st & ~rst;
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    case (state_q)
      LEN: begin
        if (accept) begin
          n_d   = s_data[IDXW-1:0];
          idx_d = '0;
          xor_d = '0;
          if (s_data > MEM_WORDS) begin
            state_d = ERR;
          end else if (s_data == 32'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wr_d    = 1'b1;
          addr_d  = BASE_ADDR + {{(30-IDXW){1'b0}}, idx_q, 2'b00};
          wdata_d = s_data;
          idx_d   = idx_q + IDXW'(1);
          xor_d   = xor_q ^ s_data;
          if (idx_q == n_q - IDXW'(1)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = (s_data == xor_q) ? RUN : ERR;
        end
      end
      default: begin
      end
    endcase
  end

  // Status flags are registered from the next state so they appear the cycle after the deciding accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LEN;
      n_q       <= '0;
      idx_q     <= '0;
      xor_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      cpu_rst_q <= (state_d != RUN);
      done_q    <= (state_d == RUN);
      err_q     <= (state_d == ERR);
    end
  end

  assign im_write = {4{wr_q}};
  assign im_addr  = addr_q;
  assign im_data  = wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are streamed in, IM writes are logged
// by a monitor, and every check runs through checkOutput.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [31:0] im_addr;
  logic [3:0]  im_write;
  logic [31:0] im_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  logic [3:0]  wrStrb[$];
  int          wrCycle[$];
  logic [31:0] frame[$];

  prog_loader #(.MEM_WORDS(100), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .im_addr(im_addr), .im_write(im_write), .im_data(im_data),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write pulse on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cycle = cycle + 1;
    if (im_write != 4'h0) begin
      wrAddr.push_back(im_addr);
      wrData.push_back(im_data);
      wrStrb.push_back(im_write);
      wrCycle.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] word, input int gap);
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = word;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic sendFrame(input int gap);
    foreach (frame[i]) applyStimulus(frame[i], gap);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".s_ready"}, {31'd0, s_ready}, 32'd0);
    checkOutput({tag, ".im_write"}, {28'd0, im_write}, 32'd0);
    checkOutput({tag, ".im_addr"}, im_addr, 32'd0);
    checkOutput({tag, ".im_data"}, im_data, 32'd0);
    checkOutput({tag, ".cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic checkStatus(input string tag, input logic expDone, input logic expErr,
                             input logic expCpuRst, input logic expReady);
    checkOutput({tag, ".done"}, {31'd0, done}, {31'd0, expDone});
    checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, expErr});
    checkOutput({tag, ".cpu_rst"}, {31'd0, cpu_rst}, {31'd0, expCpuRst});
    checkOutput({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, expReady});
  endtask

  // Compares the writes logged since 'base' against a list of data words at consecutive addresses.
  task automatic checkWrites(input string tag, input int base, input int expGap);
    checkOutput({tag, ".count"}, 32'(wrAddr.size() - base), 32'(frame.size() - 2));
    for (int i = 0; i < frame.size() - 2 && base + i < wrAddr.size(); i++) begin
      checkOutput($sformatf("%s.addr%0d", tag, i), wrAddr[base+i], 32'(4 * i));
      checkOutput($sformatf("%s.data%0d", tag, i), wrData[base+i], frame[i+1]);
      checkOutput($sformatf("%s.strb%0d", tag, i), {28'd0, wrStrb[base+i]}, 32'hF);
      if (i > 0)
        checkOutput($sformatf("%s.spacing%0d", tag, i), 32'(wrCycle[base+i] - wrCycle[base+i-1]), 32'(expGap));
    end
  endtask

  initial begin
    int base;
    logic [31:0] a, b, c, x;

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 32'd0;
    tick();
    tick();
    checkResetValues("reset");
    rst = 1'b0;
    tick();
    checkOutput("reset.ready_after", {31'd0, s_ready}, 32'd1);

    // 3-word frame, back-to-back valid
    a = 32'h00500093; b = 32'h00100113; c = 32'h002081B3;
    x = 32'h00608033;
    frame = '{32'd3, a, b, c, x};
    base = wrAddr.size();
    for (int i = 0; i < 4; i++) applyStimulus(frame[i], 0);
    checkOutput("b2b.last_wr_in_csum", {28'd0, im_write}, 32'hF);
    checkOutput("b2b.csum_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("b2b.done_before", {31'd0, done}, 32'd0);
    applyStimulus(frame[4], 0);
    checkStatus("b2b", 1'b1, 1'b0, 1'b0, 1'b0);
    checkWrites("b2b", base, 1);
    base = wrAddr.size();
    applyStimulus(32'hDEADBEEF, 0);
    tick();
    checkOutput("run.no_write", 32'(wrAddr.size() - base), 32'd0);
    checkOutput("run.done_sticky", {31'd0, done}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("run_rst.cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("run_rst.done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();

    // same frame, two idle cycles between words
    base = wrAddr.size();
    sendFrame(2);
    checkStatus("gap", 1'b1, 1'b0, 1'b0, 1'b0);
    checkWrites("gap", base, 3);

    // empty image, good and bad checksum
    doReset();
    base = wrAddr.size();
    applyStimulus(32'd0, 0);
    checkOutput("empty.done_early", {31'd0, done}, 32'd0);
    applyStimulus(32'd0, 0);
    checkStatus("empty", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("empty.no_write", 32'(wrAddr.size() - base), 32'd0);
    doReset();
    applyStimulus(32'd0, 0);
    applyStimulus(32'd1, 0);
    checkStatus("empty_bad", 1'b0, 1'b1, 1'b1, 1'b0);

    // oversize length
    doReset();
    base = wrAddr.size();
    applyStimulus(32'd101, 0);
    checkStatus("len101", 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h11111111, 0);
    applyStimulus(32'h22222222, 0);
    checkOutput("len101.no_write", 32'(wrAddr.size() - base), 32'd0);
    checkOutput("len101.err_sticky", {31'd0, err}, 32'd1);
    doReset();
    applyStimulus(32'hFFFF_FFFF, 0);
    checkOutput("lenmax.err", {31'd0, err}, 32'd1);

    // full-capacity image
    doReset();
    frame = '{32'd100};
    x = 32'd0;
    for (int i = 0; i < 100; i++) begin
      frame.push_back(32'h1357_0000 + 32'(i * 7));
      x = x ^ (32'h1357_0000 + 32'(i * 7));
    end
    frame.push_back(x);
    base = wrAddr.size();
    sendFrame(0);
    checkStatus("len100", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("len100.count", 32'(wrAddr.size() - base), 32'd100);
    if (wrAddr.size() > 0)
      checkOutput("len100.last_addr", wrAddr[wrAddr.size()-1], 32'h18C);

    // bad checksum after data
    doReset();
    a = 32'hCAFE0001; b = 32'h0BADF00D;
    frame = '{32'd2, a, b, (a ^ b) ^ 32'd1};
    base = wrAddr.size();
    sendFrame(0);
    checkStatus("badsum", 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("badsum.count", 32'(wrAddr.size() - base), 32'd2);
    if (wrAddr.size() >= 2) begin
      checkOutput("badsum.addr1", wrAddr[wrAddr.size()-1], 32'h4);
      checkOutput("badsum.data1", wrData[wrData.size()-1], b);
    end

    // reset in the middle of a load, then a clean reload
    doReset();
    a = 32'h00500093; b = 32'h00100113; c = 32'h002081B3;
    frame = '{32'd3, a, b, c, a ^ b ^ c};
    applyStimulus(frame[0], 0);
    applyStimulus(frame[1], 0);
    applyStimulus(frame[2], 0);
    rst = 1'b1;
    tick();
    checkResetValues("midrst");
    rst = 1'b0;
    tick();
    base = wrAddr.size();
    sendFrame(0);
    checkStatus("reload", 1'b1, 1'b0, 1'b0, 1'b0);
    checkWrites("reload", base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
